// File: rtl/lem1802_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lem1802_pkg
// Purpose  : Shared command codes, FSM states and dump sizes for the LEM1802 HWI block.
// Revision : 1.0
// ============================================================================
package lem1802_pkg;

  typedef enum logic [15:0] {
    CMD_MAP_SCREEN   = 16'd0,
    CMD_MAP_FONT     = 16'd1,
    CMD_MAP_PALETTE  = 16'd2,
    CMD_SET_BORDER   = 16'd3,
    CMD_DUMP_FONT    = 16'd4,
    CMD_DUMP_PALETTE = 16'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DUMP_FILL  = 2'd1,
    ST_DUMP_WRITE = 2'd2,
    ST_FINISH     = 2'd3
  } state_e;

  localparam int FONT_WORDS_DEFAULT = 256;
  localparam int PAL_WORDS_DEFAULT  = 16;
  localparam int CNT_W              = 17;

endpackage
`default_nettype wire

// File: rtl/lem1802_dump_seq.sv
`default_nettype none
// ============================================================================
// Module   : lem1802_dump_seq
// Purpose  : ROM-to-RAM copy sequencer: index counter, ROM address and DMA write path.
// Revision : 1.0
// ============================================================================
module lem1802_dump_seq
  import lem1802_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [15:0]      i_base,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_run,
  input  logic             i_write,
  input  logic [15:0]      i_rom_data,
  output logic [7:0]       o_rom_addr,
  output logic [15:0]      o_dma_addr,
  output logic [15:0]      o_dma_data,
  output logic             o_last
);

  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_waddr;
  logic [15:0]      r_addr_hold;
  logic [15:0]      r_data_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_count     <= '0;
      r_waddr     <= '0;
      r_addr_hold <= '0;
      r_data_hold <= '0;
    end else begin
      if (i_start) begin
        r_idx   <= '0;
        r_count <= i_count;
        r_waddr <= i_base;
      end else if (i_run) begin
        r_idx <= r_idx + 1'b1;
      end
      if (i_write) begin
        r_waddr     <= r_waddr + 16'd1;
        r_addr_hold <= r_waddr;
        r_data_hold <= i_rom_data;
      end
    end
  end

  // ROM is one index ahead of the write, so idx == count marks word N-1.
  assign o_rom_addr = r_idx[7:0];
  assign o_last     = i_write && (r_idx == r_count);
  assign o_dma_addr = i_write ? r_waddr : r_addr_hold;
  assign o_dma_data = i_write ? i_rom_data : r_data_hold;

endmodule
`default_nettype wire

// File: rtl/lem1802_hwi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lem1802_hwi_ctrl
// Purpose  : LEM1802 HWI command decoder and font/palette dump controller.
//            Dumps are built only when LEM1802_DUMP_EN is defined.
// Revision : 1.0
// ============================================================================
module lem1802_hwi_ctrl
  import lem1802_pkg::*;
#(
  parameter int FONT_WORDS = FONT_WORDS_DEFAULT,
  parameter int PAL_WORDS  = PAL_WORDS_DEFAULT
) (
  input  logic        DMA_CLOCK,
  input  logic        RESET,
  input  logic        hwi_req,
  input  logic [15:0] hwi_a,
  input  logic [15:0] hwi_b,
  output logic        hwi_busy,
  output logic        hwi_done,
  output logic [15:0] screen_base,
  output logic        screen_en,
  output logic [15:0] font_base,
  output logic        font_custom,
  output logic [15:0] pal_base,
  output logic        pal_custom,
  output logic [3:0]  border_colour,
  output logic [7:0]  dflt_addr,
  output logic        dflt_sel,
  input  logic [15:0] dflt_data,
  output logic [15:0] DMA_addr,
  output logic [15:0] DMA_data,
  output logic        DMA_wren
);

  state_e      r_state;
  state_e      w_next;
  logic        w_accept;
  logic        w_is_dump;
  logic        w_last;
  logic        w_busy;
  logic        w_write;
  logic        w_finish;
  logic        r_done;
  logic [15:0] r_screen_base;
  logic [15:0] r_font_base;
  logic [15:0] r_pal_base;
  logic [3:0]  r_border;

  assign w_accept = (r_state == ST_IDLE) && hwi_req;

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_write  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_dump) w_next = ST_DUMP_FILL;
      end
      ST_DUMP_FILL: begin
        w_busy = 1'b1;
        w_next = ST_DUMP_WRITE;
      end
      ST_DUMP_WRITE: begin
        w_busy  = 1'b1;
        w_write = 1'b1;
        if (w_last) w_next = ST_FINISH;
      end
      ST_FINISH: begin
        w_finish = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge DMA_CLOCK) begin
    if (RESET) begin
      r_state       <= ST_IDLE;
      r_done        <= 1'b0;
      r_screen_base <= '0;
      r_font_base   <= '0;
      r_pal_base    <= '0;
      r_border      <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_accept && !w_is_dump;
      if (w_accept) begin
        case (hwi_a)
          CMD_MAP_SCREEN:  r_screen_base <= hwi_b;
          CMD_MAP_FONT:    r_font_base   <= hwi_b;
          CMD_MAP_PALETTE: r_pal_base    <= hwi_b;
          CMD_SET_BORDER:  r_border      <= hwi_b[3:0];
          default: ;
        endcase
      end
    end
  end

  assign hwi_busy      = w_busy;
  assign hwi_done      = r_done | w_finish;
  assign DMA_wren      = w_write;
  assign screen_base   = r_screen_base;
  assign screen_en     = (r_screen_base != 16'd0);
  assign font_base     = r_font_base;
  assign font_custom   = (r_font_base != 16'd0);
  assign pal_base      = r_pal_base;
  assign pal_custom    = (r_pal_base != 16'd0);
  assign border_colour = r_border;

`ifdef LEM1802_DUMP_EN
  logic             r_sel;
  logic             w_start;
  logic [CNT_W-1:0] w_count;

  assign w_is_dump = (hwi_a == CMD_DUMP_FONT) || (hwi_a == CMD_DUMP_PALETTE);
  assign w_start   = w_accept && w_is_dump;
  assign w_count   = (hwi_a == CMD_DUMP_PALETTE) ? CNT_W'(PAL_WORDS) : CNT_W'(FONT_WORDS);

  always_ff @(posedge DMA_CLOCK) begin
    if (RESET) begin
      r_sel <= 1'b0;
    end else if (w_start) begin
      r_sel <= (hwi_a == CMD_DUMP_PALETTE);
    end
  end

  assign dflt_sel = r_sel;

  lem1802_dump_seq u_dump_seq (
    .clk        (DMA_CLOCK),
    .rst        (RESET),
    .i_start    (w_start),
    .i_base     (hwi_b),
    .i_count    (w_count),
    .i_run      (w_busy),
    .i_write    (w_write),
    .i_rom_data (dflt_data),
    .o_rom_addr (dflt_addr),
    .o_dma_addr (DMA_addr),
    .o_dma_data (DMA_data),
    .o_last     (w_last)
  );
`else
  // Dump commands complete as plain no-ops; the ROM interface is parked.
  logic [CNT_W-1:0] w_unused_cfg;

  assign w_is_dump    = 1'b0;
  assign w_last       = 1'b0;
  assign dflt_addr    = '0;
  assign dflt_sel     = 1'b0;
  assign DMA_addr     = '0;
  assign DMA_data     = '0;
  assign w_unused_cfg = {1'b0, dflt_data} ^ CNT_W'(FONT_WORDS) ^ CNT_W'(PAL_WORDS);
`endif

endmodule
`default_nettype wire

// File: tb/tb_lem1802_hwi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lem1802_hwi_ctrl
// Purpose  : Directed self-checking bench; expectations follow LEM1802_DUMP_EN.
// Revision : 1.0
// ============================================================================
module tb_lem1802_hwi_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic        busy, done, scr_en, fnt_cus, pal_cus, sel, wren;
  logic [15:0] scr_base, fnt_base, pl_base, daddr, ddata;
  logic [3:0]  border;
  logic [7:0]  raddr;
  logic [15:0] rom_q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  lem1802_hwi_ctrl dut (
    .DMA_CLOCK     (clk),
    .RESET         (rst),
    .hwi_req       (req),
    .hwi_a         (a),
    .hwi_b         (b),
    .hwi_busy      (busy),
    .hwi_done      (done),
    .screen_base   (scr_base),
    .screen_en     (scr_en),
    .font_base     (fnt_base),
    .font_custom   (fnt_cus),
    .pal_base      (pl_base),
    .pal_custom    (pal_cus),
    .border_colour (border),
    .dflt_addr     (raddr),
    .dflt_sel      (sel),
    .dflt_data     (rom_q),
    .DMA_addr      (daddr),
    .DMA_data      (ddata),
    .DMA_wren      (wren)
  );

  always #5 clk = ~clk;

  // Built-in ROM model: registered read, returns 0x0A00 + address.
  always @(posedge clk) rom_q <= 16'h0A00 + {8'h00, raddr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [15:0] ca, input logic [15:0] cb);
    req = 1'b1;
    a   = ca;
    b   = cb;
    tick();
    req = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " screen_base"}, scr_base, 32'h0);
    check({tag, " screen_en"},   scr_en,   32'h0);
    check({tag, " font_base"},   fnt_base, 32'h0);
    check({tag, " font_custom"}, fnt_cus,  32'h0);
    check({tag, " pal_base"},    pl_base,  32'h0);
    check({tag, " pal_custom"},  pal_cus,  32'h0);
    check({tag, " border"},      border,   32'h0);
    check({tag, " busy"},        busy,     32'h0);
    check({tag, " done"},        done,     32'h0);
    check({tag, " wren"},        wren,     32'h0);
    check({tag, " dflt_sel"},    sel,      32'h0);
    check({tag, " dflt_addr"},   raddr,    32'h0);
    check({tag, " dma_addr"},    daddr,    32'h0);
    check({tag, " dma_data"},    ddata,    32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset("reset");

    cmd(16'd0, 16'h8000);
    check("map_screen base", scr_base, 32'h8000);
    check("map_screen en",   scr_en,   32'h1);
    check("map_screen done", done,     32'h1);
    check("map_screen busy", busy,     32'h0);
    tick();
    check("done one cycle",  done,     32'h0);

    cmd(16'd0, 16'h0000);
    check("screen off base", scr_base, 32'h0);
    check("screen off en",   scr_en,   32'h0);

    cmd(16'd3, 16'hFFF7);
    check("border 7",        border,   32'h7);
    check("border done",     done,     32'h1);
    cmd(16'd1, 16'h1234);
    check("font base set",   fnt_base, 32'h1234);
    check("font custom set", fnt_cus,  32'h1);
    check("b2b done",        done,     32'h1);
    cmd(16'd1, 16'h0000);
    check("font base clr",   fnt_base, 32'h0);
    check("font custom clr", fnt_cus,  32'h0);
    cmd(16'd2, 16'h5555);
    check("pal base",        pl_base,  32'h5555);
    check("pal custom",      pal_cus,  32'h1);
    cmd(16'd7, 16'hFFFF);
    check("unknown done",    done,     32'h1);
    check("unknown border",  border,   32'h7);
    check("unknown screen",  scr_base, 32'h0);
    check("unknown pal",     pl_base,  32'h5555);
    tick();

    // Palette dump to 0x9000.
    cmd(16'd5, 16'h9000);
`ifdef LEM1802_DUMP_EN
    check("pal fill busy",  busy,  32'h1);
    check("pal fill addr",  raddr, 32'h0);
    check("pal fill sel",   sel,   32'h1);
    check("pal fill wren",  wren,  32'h0);
    check("pal fill done",  done,  32'h0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("pal wren",      wren,  32'h1);
      check("pal dma_addr",  daddr, 32'(16'h9000 + 16'(i)));
      check("pal dma_data",  ddata, 32'(16'h0A00 + 16'(i)));
      check("pal rom_addr",  raddr, 32'(i + 1));
      check("pal busy",      busy,  32'h1);
      check("pal done early", done, 32'h0);
    end
    tick();
    check("pal finish done", done,  32'h1);
    check("pal finish busy", busy,  32'h0);
    check("pal finish wren", wren,  32'h0);
    check("pal hold addr",   daddr, 32'h900F);
    check("pal hold data",   ddata, 32'h0A0F);
    check("pal map kept",    pl_base, 32'h5555);
    tick();
    check("pal done once",   done,  32'h0);
`else
    check("pal noop done", done, 32'h1);
    check("pal noop busy", busy, 32'h0);
    check("pal noop wren", wren, 32'h0);
    check("pal noop sel",  sel,  32'h0);
    tick();
    check("pal noop wren2", wren, 32'h0);
    check("pal noop done2", done, 32'h0);
`endif

    // Font dump to 0xFFF0 wraps through 0x0000; a MAP_FONT is dropped mid-dump.
    cmd(16'd4, 16'hFFF0);
`ifdef LEM1802_DUMP_EN
    check("font fill busy", busy,  32'h1);
    check("font fill sel",  sel,   32'h0);
    check("font fill addr", raddr, 32'h0);
    for (int t = 2; t <= 258; t++) begin
      tick();
      if (t <= 257) begin
        check("font wren",     wren,  32'h1);
        check("font dma_addr", daddr, 32'(16'hFFF0 + 16'(t - 2)));
        check("font dma_data", ddata, 32'(16'h0A00 + 16'(t - 2)));
        check("font done early", done, 32'h0);
      end else begin
        check("font finish done", done, 32'h1);
        check("font finish busy", busy, 32'h0);
        check("font finish wren", wren, 32'h0);
        check("font last addr",   daddr, 32'h00EF);
      end
      if (t == 4) begin
        req = 1'b1;
        a   = 16'd1;
        b   = 16'hBEEF;
      end else if (t == 5) begin
        req = 1'b0;
      end
    end
    tick();
    check("dropped done",     done,    32'h0);
    check("dropped font_base", fnt_base, 32'h0);
    check("dropped font_cus", fnt_cus, 32'h0);
`else
    check("font noop done", done, 32'h1);
    check("font noop busy", busy, 32'h0);
    check("font noop wren", wren, 32'h0);
    tick();
    check("font noop idle", done, 32'h0);
`endif

    // Reset on the fifth write of a font dump.
    cmd(16'd4, 16'h1000);
    repeat (5) tick();
`ifdef LEM1802_DUMP_EN
    check("abort pre wren", wren,  32'h1);
    check("abort pre addr", daddr, 32'h1004);
`endif
    rst = 1'b1;
    tick();
    check_reset("abort");
    rst = 1'b0;
    tick();
    check("abort no done a", done, 32'h0);
    tick();
    check("abort no done b", done, 32'h0);
    check("abort wren",      wren, 32'h0);
    cmd(16'd0, 16'h8000);
    check("post base", scr_base, 32'h8000);
    check("post en",   scr_en,   32'h1);
    check("post done", done,     32'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
